// File: rtl/phy_reset_sequencer.sv
// -----------------------------------------------------------------------------
// phy_reset_sequencer
//
// Purpose:
//   Brings one SATA PHY lane out of reset in a fixed order. The order is PLL
//   power-down, TX analog, TX digital, RX analog, then RX digital. It then
//   raises ready. The async PHY status inputs are synchronized first. The
//   sequence restarts on a lock timeout or a loss of lock.
//
// Optional build macro:
//   PHY_RESET_SEQ_STATUS_EN - when defined, adds the debug outputs state_code
//   and retry_cnt.
//
// Ports:
//   clk              in   single clock
//   reset_n          in   async active-low reset
//   pll_locked       in   async, TX PLL lock
//   cal_busy         in   async, PHY calibration in progress
//   cdr_locked       in   async, RX CDR locked to data
//   pll_powerdown    out  PLL power-down
//   tx_analogreset   out  TX PMA reset
//   tx_digitalreset  out  TX PCS reset
//   rx_analogreset   out  RX PMA reset
//   rx_digitalreset  out  RX PCS reset
//   ready            out  lane fully out of reset
//   state_code[2:0]  out  (STATUS_EN) current state, PLL_PD=0 .. READY=6
//   retry_cnt[7:0]   out  (STATUS_EN) saturating count of timeouts/lock losses
// -----------------------------------------------------------------------------

// Two-flop (plus optional extra stages) synchronizer, async active-high clear.
module ff_synchronizer #(
  parameter int EXTRA_STAGES = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  localparam int STAGES = 2 + EXTRA_STAGES;

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain <= '0;
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];
endmodule

// State table
//   state      | meaning
//   PLL_PD     | PLL held powered down, everything in reset
//   WAIT_PLL   | PLL released, waiting for lock and calibration done
//   TX_SETTLE  | TX PMA released, letting it settle before PCS release
//   RX_PD      | TX fully released, RX PMA still held in reset
//   WAIT_CDR   | RX PMA released, waiting for CDR lock
//   CDR_SETTLE | CDR locked, qualifying that lock stays stable
//   READY      | all resets released, lane ready
module phy_reset_sequencer #(
  parameter int PLL_PD_CYCLES     = 1000,
  parameter int SETTLE_CYCLES     = 100,
  parameter int LOCK_TIMEOUT      = 65536,
  parameter int SYNC_EXTRA_STAGES = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       cal_busy,
  input  logic       cdr_locked,
  output logic       pll_powerdown,
  output logic       tx_analogreset,
  output logic       tx_digitalreset,
  output logic       rx_analogreset,
  output logic       rx_digitalreset,
  output logic       ready
`ifdef PHY_RESET_SEQ_STATUS_EN
  ,
  output logic [2:0] state_code,
  output logic [7:0] retry_cnt
`endif
);

  typedef enum logic [2:0] {
    PLL_PD     = 3'd0,
    WAIT_PLL   = 3'd1,
    TX_SETTLE  = 3'd2,
    RX_PD      = 3'd3,
    WAIT_CDR   = 3'd4,
    CDR_SETTLE = 3'd5,
    READY      = 3'd6
  } state_t;

  // One counter serves every timed state, so size it for the longest interval.
  localparam int MAX_A = (PLL_PD_CYCLES > SETTLE_CYCLES) ? PLL_PD_CYCLES : SETTLE_CYCLES;
  localparam int MAX_N = (MAX_A > LOCK_TIMEOUT) ? MAX_A : LOCK_TIMEOUT;
  localparam int CW    = (MAX_N > 1) ? $clog2(MAX_N) : 1;

  localparam logic [CW-1:0] LD_PLL_PD = CW'(PLL_PD_CYCLES - 1);
  localparam logic [CW-1:0] LD_SETTLE = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] LD_LOCK   = CW'(LOCK_TIMEOUT - 1);

  // Bit order: pll_pd, tx_ana, tx_dig, rx_ana, rx_dig, ready
  localparam logic [5:0] OUTS_RESET = 6'b111110;

  logic          rst_sync;
  logic          pll_locked_s;
  logic          cal_busy_s;
  logic          cdr_locked_s;
  state_t        state;
  state_t        next_state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] load_val;
  logic [5:0]    outs_q;
  logic [5:0]    outs_next;
  logic          cnt_zero;
  logic          pll_bad;

  assign rst_sync = ~reset_n;

  ff_synchronizer #(.EXTRA_STAGES(SYNC_EXTRA_STAGES)) u_sync_pll (
    .clk (clk), .rst (rst_sync), .d (pll_locked), .q (pll_locked_s)
  );
  ff_synchronizer #(.EXTRA_STAGES(SYNC_EXTRA_STAGES)) u_sync_cal (
    .clk (clk), .rst (rst_sync), .d (cal_busy), .q (cal_busy_s)
  );
  ff_synchronizer #(.EXTRA_STAGES(SYNC_EXTRA_STAGES)) u_sync_cdr (
    .clk (clk), .rst (rst_sync), .d (cdr_locked), .q (cdr_locked_s)
  );

  assign cnt_zero = (cnt == '0);
  assign pll_bad  = !pll_locked_s || cal_busy_s;

  always_comb begin
    next_state = state;
    case (state)
      PLL_PD:     if (cnt_zero) next_state = WAIT_PLL;
      WAIT_PLL: begin
        if (!pll_bad)      next_state = TX_SETTLE;
        else if (cnt_zero) next_state = PLL_PD;
      end
      TX_SETTLE:  if (cnt_zero) next_state = RX_PD;
      RX_PD:      if (cnt_zero) next_state = WAIT_CDR;
      WAIT_CDR: begin
        if (cdr_locked_s)  next_state = CDR_SETTLE;
        else if (cnt_zero) next_state = RX_PD;
      end
      CDR_SETTLE: begin
        if (!cdr_locked_s) next_state = WAIT_CDR;
        else if (cnt_zero) next_state = READY;
      end
      READY:      if (!cdr_locked_s) next_state = RX_PD;
      default:    next_state = PLL_PD;
    endcase
    // Once past WAIT_PLL, losing the PLL (or recalibration) trumps everything.
    if (state != PLL_PD && state != WAIT_PLL && pll_bad) next_state = PLL_PD;
  end

  always_comb begin
    load_val = LD_SETTLE;
    case (next_state)
      PLL_PD:             load_val = LD_PLL_PD;
      WAIT_PLL, WAIT_CDR: load_val = LD_LOCK;
      default:            load_val = LD_SETTLE;
    endcase
  end

  // Outputs decode the next state so they change on the same edge as state.
  always_comb begin
    outs_next = OUTS_RESET;
    case (next_state)
      PLL_PD:     outs_next = 6'b111110;
      WAIT_PLL:   outs_next = 6'b011110;
      TX_SETTLE:  outs_next = 6'b001110;
      RX_PD:      outs_next = 6'b000110;
      WAIT_CDR:   outs_next = 6'b000010;
      CDR_SETTLE: outs_next = 6'b000010;
      READY:      outs_next = 6'b000001;
      default:    outs_next = OUTS_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= PLL_PD;
      cnt    <= LD_PLL_PD;
      outs_q <= OUTS_RESET;
    end else begin
      state  <= next_state;
      outs_q <= outs_next;
      if (next_state != state) cnt <= load_val;
      else if (!cnt_zero)      cnt <= cnt - CW'(1);
    end
  end

  assign {pll_powerdown, tx_analogreset, tx_digitalreset,
          rx_analogreset, rx_digitalreset, ready} = outs_q;

`ifdef PHY_RESET_SEQ_STATUS_EN
  logic       retry_inc;
  logic [7:0] retry_q;

  // Timeout exits are the only WAIT_PLL->PLL_PD and WAIT_CDR->RX_PD paths.
  // An exit from READY that is caused only by recalibration is not a lock loss.
  always_comb begin
    retry_inc = 1'b0;
    if ((state == WAIT_PLL && next_state == PLL_PD) ||
        (state == WAIT_CDR && next_state == RX_PD)  ||
        (state == READY && next_state != READY && (!pll_locked_s || !cdr_locked_s)))
      retry_inc = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          retry_q <= 8'd0;
    else if (retry_inc && retry_q != 8'hFF) retry_q <= retry_q + 8'd1;
  end

  assign state_code = state;
  assign retry_cnt  = retry_q;
`endif

endmodule

// File: tb/tb_phy_reset_sequencer.sv
module tb_phy_reset_sequencer;
  logic clk        = 1'b0;
  logic reset_n    = 1'b0;
  logic pll_locked = 1'b0;
  logic cal_busy   = 1'b0;
  logic cdr_locked = 1'b0;
  logic pll_powerdown, tx_analogreset, tx_digitalreset;
  logic rx_analogreset, rx_digitalreset, ready;
`ifdef PHY_RESET_SEQ_STATUS_EN
  logic [2:0] state_code;
  logic [7:0] retry_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  phy_reset_sequencer #(
    .PLL_PD_CYCLES     (8),
    .SETTLE_CYCLES     (4),
    .LOCK_TIMEOUT      (32),
    .SYNC_EXTRA_STAGES (0)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .pll_locked      (pll_locked),
    .cal_busy        (cal_busy),
    .cdr_locked      (cdr_locked),
    .pll_powerdown   (pll_powerdown),
    .tx_analogreset  (tx_analogreset),
    .tx_digitalreset (tx_digitalreset),
    .rx_analogreset  (rx_analogreset),
    .rx_digitalreset (rx_digitalreset),
    .ready           (ready)
`ifdef PHY_RESET_SEQ_STATUS_EN
    ,
    .state_code      (state_code),
    .retry_cnt       (retry_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Advance n rising edges, then sit 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] outs();
    return {2'b00, pll_powerdown, tx_analogreset, tx_digitalreset,
            rx_analogreset, rx_digitalreset, ready};
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  // Reset with given status levels and release. Edge numbering starts after release.
  task automatic start(input logic pll, input logic cdr, input logic cal, input string tag);
    @(posedge clk);
    #1;
    reset_n    = 1'b0;
    pll_locked = pll;
    cdr_locked = cdr;
    cal_busy   = cal;
    step(2);
    chk({tag, "_rst"}, outs(), 8'b00111110);
    reset_n = 1'b1;
  endtask

  initial begin
    // Nominal bring-up
    start(1'b1, 1'b1, 1'b0, "t1");
    step(7);  chk("t1_e7_pd",       outs(), 8'b00111110);
    step(1);  chk("t1_e8_waitpll",  outs(), 8'b00011110);
    step(1);  chk("t1_e9_txana",    outs(), 8'b00001110);
    step(3);  chk("t1_e12_txset",   outs(), 8'b00001110);
    step(1);  chk("t1_e13_txdig",   outs(), 8'b00000110);
    step(3);  chk("t1_e16_rxpd",    outs(), 8'b00000110);
    step(1);  chk("t1_e17_rxana",   outs(), 8'b00000010);
    step(4);  chk("t1_e21_settle",  outs(), 8'b00000010);
    step(1);  chk("t1_e22_ready",   outs(), 8'b00000001);
`ifdef PHY_RESET_SEQ_STATUS_EN
    chk("t1_state", {5'd0, state_code}, 8'd6);
    chk("t1_retry", retry_cnt, 8'd0);
`endif

    // PLL never locks: WAIT_PLL times out after 32, PLL_PD 8, repeat
    start(1'b0, 1'b1, 1'b0, "t2");
    step(39); chk("t2_e39_waitpll", outs(), 8'b00011110);
    step(1);  chk("t2_e40_timeout", outs(), 8'b00111110);
`ifdef PHY_RESET_SEQ_STATUS_EN
    chk("t2_retry1", retry_cnt, 8'd1);
`endif
    step(7);  chk("t2_e47_pd",      outs(), 8'b00111110);
    step(1);  chk("t2_e48_waitpll", outs(), 8'b00011110);
    step(31); chk("t2_e79_waitpll", outs(), 8'b00011110);
    step(1);  chk("t2_e80_timeout", outs(), 8'b00111110);
`ifdef PHY_RESET_SEQ_STATUS_EN
    chk("t2_retry2", retry_cnt, 8'd2);
`endif

    // One-cycle CDR drop while READY: RX side re-resets, TX stays released
    start(1'b1, 1'b1, 1'b0, "t3");
    step(24); cdr_locked = 1'b0;
    step(1);  cdr_locked = 1'b1;
    step(1);  chk("t3_e26_still",   outs(), 8'b00000001);
    step(1);  chk("t3_e27_rxpd",    outs(), 8'b00000110);
    step(3);  chk("t3_e30_rxpd",    outs(), 8'b00000110);
    step(1);  chk("t3_e31_waitcdr", outs(), 8'b00000010);
    step(4);  chk("t3_e35_settle",  outs(), 8'b00000010);
    step(1);  chk("t3_e36_ready",   outs(), 8'b00000001);
`ifdef PHY_RESET_SEQ_STATUS_EN
    chk("t3_retry", retry_cnt, 8'd1);
`endif

    // CDR glitch seen in CDR_SETTLE: settle restarts, ready moves 22 -> 25
    start(1'b1, 1'b1, 1'b0, "t4");
    step(17); cdr_locked = 1'b0;
    step(1);  cdr_locked = 1'b1;
    step(4);  chk("t4_e22_notready", outs(), 8'b00000010);
    step(2);  chk("t4_e24_settle",   outs(), 8'b00000010);
    step(1);  chk("t4_e25_ready",    outs(), 8'b00000001);

    // PLL and CDR lost together in READY: PLL_PD wins, full rerun
    start(1'b1, 1'b1, 1'b0, "t5");
    step(24); pll_locked = 1'b0; cdr_locked = 1'b0;
    step(2);  chk("t5_e26_still",   outs(), 8'b00000001);
    step(1);  chk("t5_e27_pllpd",   outs(), 8'b00111110);
`ifdef PHY_RESET_SEQ_STATUS_EN
    chk("t5_state", {5'd0, state_code}, 8'd0);
    chk("t5_retry", retry_cnt, 8'd1);
`endif
    pll_locked = 1'b1; cdr_locked = 1'b1;
    step(7);  chk("t5_e34_pd",      outs(), 8'b00111110);
    step(1);  chk("t5_e35_waitpll", outs(), 8'b00011110);
    step(13); chk("t5_e48_settle",  outs(), 8'b00000010);
    step(1);  chk("t5_e49_ready",   outs(), 8'b00000001);

    // Recalibration in READY forces PLL_PD and holds WAIT_PLL until done
    start(1'b1, 1'b1, 1'b0, "t6");
    step(24); cal_busy = 1'b1;
    step(3);  chk("t6_e27_pllpd",   outs(), 8'b00111110);
    step(8);  chk("t6_e35_waitpll", outs(), 8'b00011110);
    step(2);  cal_busy = 1'b0;
    step(2);  chk("t6_e39_waitpll", outs(), 8'b00011110);
    step(1);  chk("t6_e40_txana",   outs(), 8'b00001110);

    // Async reset in TX_SETTLE, checked with no clock edge in between
    start(1'b1, 1'b1, 1'b0, "t7");
    step(10); chk("t7_e10_txset",   outs(), 8'b00001110);
    #3 reset_n = 1'b0;
    #1 chk("t7_async",              outs(), 8'b00111110);
    @(posedge clk);
    #1 reset_n = 1'b1;
    step(7);  chk("t7_e7_pd",       outs(), 8'b00111110);
    step(1);  chk("t7_e8_waitpll",  outs(), 8'b00011110);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
